// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with per-register load scoreboard and read bypassing.
//   Register NREGS-1 is a hard zero register: it reads 0, ignores writes,
//   and never becomes pending.
//
//   Optional build macro REGFILE_SB_INIT_EN adds a clear sequencer. After
//   reset it walks registers 0..NREGS-2 and writes 0 to each, one per
//   cycle. While it runs, init_busy=1, stall=1, and ld/we writes and
//   load issues are dropped. Without the macro, the block is always in
//   RUN, init_busy=0, and array contents after reset are unspecified.
//
//   Handshake: there is no back-pressure on any input. stall is advisory
//   to the issuing pipeline, which must hold its read until stall=0. ld
//   and we writes are accepted on every edge unless init_busy=1.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rd_en/rd_addr/rd_data         NRD combinational read ports (packed)
//   stall                         read-after-load hazard or init active
//   init_busy                     clear sequence active
//   iss_valid/iss_dst/iss_is_load instruction issue (sets pending on loads)
//   ld_valid/ld_addr/ld_data      load return write port (clears pending)
//   we/wa/wd                      ALU writeback port
//   byp_valid/byp_addr/byp_data   NBYP bypass sources, index 0 youngest
//   dbg_state/dbg_cnt             sequencer state and clear counter
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NBYP   = 3,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic                   stall,
    output logic                   init_busy,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_dst,
    input  logic                   iss_is_load,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [DATA_W-1:0]      wd,
    input  logic [NBYP-1:0]        byp_valid,
    input  logic [NBYP*AW-1:0]     byp_addr,
    input  logic [NBYP*DATA_W-1:0] byp_data,
    output logic [0:0]             dbg_state,
    output logic [AW-1:0]          dbg_cnt
);

    localparam logic [AW-1:0] ZR     = AW'(NREGS - 1);
    localparam logic [0:0]    ST_RUN = 1'b1;

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  pending;
    logic              stall_hz;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
`ifdef REGFILE_SB_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;

    logic [0:0]    state;
    logic [AW-1:0] cnt;

    // cnt stops at NREGS-2 (the last non-zero register) and does not wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == AW'(NREGS - 2)) state <= ST_RUN;
                    else                       cnt   <= cnt + 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign init_busy = (state == ST_INIT);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign stall     = init_busy | stall_hz;
`else
    assign init_busy = 1'b0;
    assign dbg_state = ST_RUN;
    assign dbg_cnt   = '0;
    // Pending bits may still be set before rst takes effect; hide them.
    assign stall     = stall_hz & ~rst;
`endif

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    // ld is written after we, so a same-address collision stores ld_data.
    always_ff @(posedge clk) begin
        if (!init_busy) begin
            if (we && wa != ZR)             mem[wa]      <= wd;
            if (ld_valid && ld_addr != ZR)  mem[ld_addr] <= ld_data;
        end
`ifdef REGFILE_SB_INIT_EN
        if (!rst && state == ST_INIT) mem[cnt] <= '0;
`endif
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // The set is evaluated after the clear, so a load issued in the same
    // cycle its register's previous load returns keeps the bit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (ld_valid && ld_addr == AW'(r))
                    pending[r] <= 1'b0;
                if (iss_valid && iss_is_load && !init_busy &&
                    iss_dst == AW'(r) && r != NREGS - 1)
                    pending[r] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Priority from lowest to highest is applied in statement order:
    // array, we, ld, bypass (scanned oldest to youngest), zero register.
    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
        if (we && wa == a)            v = wd;
        if (ld_valid && ld_addr == a) v = ld_data;
        for (int b = NBYP - 1; b >= 0; b--) begin
            if (byp_valid[b] && byp_addr[b*AW +: AW] == a)
                v = byp_data[b*DATA_W +: DATA_W];
        end
        if (a == ZR) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NRD; p++)
            rd_data[p*DATA_W +: DATA_W] = read_port(rd_addr[p*AW +: AW]);
    end

    // A pending register does not stall if its load returns this cycle;
    // the read port already forwards ld_data in that case.
    always_comb begin
        logic [AW-1:0] ra;
        stall_hz = 1'b0;
        ra       = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (rd_en[p] && pending[ra] && !(ld_valid && ld_addr == ra))
                stall_hz = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
`timescale 1ns/1ps
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    rd_en;
    logic [9:0]    rd_addr;
    logic [63:0]   rd_data;
    logic          stall, init_busy;
    logic          iss_valid, iss_is_load;
    logic [AW-1:0] iss_dst;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [2:0]    byp_valid;
    logic [14:0]   byp_addr;
    logic [95:0]   byp_data;
    logic [0:0]    dbg_state;
    logic [AW-1:0] dbg_cnt;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NBYP(3)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .stall(stall), .init_busy(init_busy),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_is_load(iss_is_load),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .we(we), .wa(wa), .wd(wd),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    bv;
        logic [AW-1:0] ba0; logic [DW-1:0] bd0;
        logic [AW-1:0] ba1; logic [DW-1:0] bd1;
        logic [AW-1:0] ba2; logic [DW-1:0] bd2;
        logic          we;  logic [AW-1:0] wa; logic [DW-1:0] wd;
        logic          ldv; logic [AW-1:0] la; logic [DW-1:0] ld;
        logic [AW-1:0] ra0; logic [AW-1:0] ra1;
        logic [DW-1:0] exp0; logic [DW-1:0] exp1;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 2'b00; rd_addr = '0;
        iss_valid = 1'b0; iss_dst = '0; iss_is_load = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        we = 1'b0; wa = '0; wd = '0;
        byp_valid = '0; byp_addr = '0; byp_data = '0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en = en;
        rd_addr = {a1, a0};
    endtask

    // scoreboard
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef REGFILE_SB_INIT_EN
    // Entered in a cycle where rst is already low; counts busy cycles.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            #2;
            if (!init_busy) break;
            n++;
            step();
        end
    endtask
    int busy_n;
`endif

    initial begin
        vecs[0]  = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b1,5'd3,32'hA,        1'b0,5'd0,32'h0,  5'd3, 5'd4,  32'hA, 32'h0};
        vecs[1]  = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 5'd31, 32'hA, 32'h0};
        vecs[2]  = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b1,5'd3,32'hC,        1'b1,5'd3,32'hB,  5'd3, 5'd3,  32'hB, 32'hB};
        vecs[3]  = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 5'd6,  32'hB, 32'h0};
        vecs[4]  = '{3'b011, 5'd7,32'h11,5'd7,32'h22,5'd0,32'h0, 1'b1,5'd7,32'h33,       1'b0,5'd0,32'h0,  5'd7, 5'd3,  32'h11,32'hB};
        vecs[5]  = '{3'b010, 5'd0,32'h0, 5'd7,32'h22,5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd7, 5'd7,  32'h22,32'h22};
        vecs[6]  = '{3'b100, 5'd0,32'h0, 5'd0,32'h0, 5'd3,32'h44,1'b0,5'd0,32'h0,        1'b1,5'd3,32'h55, 5'd3, 5'd7,  32'h44,32'h33};
        vecs[7]  = '{3'b001, 5'd8,32'h66,5'd0,32'h0, 5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 5'd8,  32'h55,32'h66};
        vecs[8]  = '{3'b001, 5'd31,32'h77,5'd0,32'h0,5'd0,32'h0, 1'b1,5'd31,32'hFFFF_FFFF,1'b0,5'd0,32'h0, 5'd31,5'd31, 32'h0, 32'h0};
        vecs[9]  = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd31,5'd8,  32'h0, 32'h0};
        vecs[10] = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b1,5'd0,32'h99,       1'b1,5'd1,32'h88, 5'd0, 5'd1,  32'h99,32'h88};
        vecs[11] = '{3'b000, 5'd0,32'h0, 5'd0,32'h0, 5'd0,32'h0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd0, 5'd1,  32'h99,32'h88};

        idle();
        rst = 1'b1;
        repeat (3) step();
        #2;
`ifdef REGFILE_SB_INIT_EN
        check("rst_init_busy", {31'd0, init_busy}, 32'd1);
        check("rst_stall",     {31'd0, stall},     32'd1);
`else
        check("rst_init_busy", {31'd0, init_busy}, 32'd0);
        check("rst_stall",     {31'd0, stall},     32'd0);
`endif

        // release reset; in the init build, writes and issues during the
        // clear must be dropped
        step();
        rst = 1'b0;
`ifdef REGFILE_SB_INIT_EN
        we = 1'b1; wa = 5'd2; wd = 32'hBAD;
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd4;
        count_busy(busy_n);
        idle();
        check("init_busy_len", busy_n, 32'd31);
        step();
        rd(2'b01, 5'd4, 5'd0);
        #2;
        check("post_init_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < NR; i++) begin
            rd(2'b11, AW'(i), AW'(NR - 1 - i));
            #1;
            check($sformatf("init_zero_r%0d", i), rd_data[31:0], 32'h0);
            step();
        end
        idle();
`endif

        // known contents for the vector table
        for (int i = 0; i < NR - 1; i++) begin
            step();
            we = 1'b1; wa = AW'(i); wd = '0;
        end
        step();
        idle();

        // table-driven read priority / write visibility
        for (int i = 0; i < NV; i++) begin
            step();
            byp_valid = vecs[i].bv;
            byp_addr  = {vecs[i].ba2, vecs[i].ba1, vecs[i].ba0};
            byp_data  = {vecs[i].bd2, vecs[i].bd1, vecs[i].bd0};
            we = vecs[i].we;  wa = vecs[i].wa; wd = vecs[i].wd;
            ld_valid = vecs[i].ldv; ld_addr = vecs[i].la; ld_data = vecs[i].ld;
            rd(2'b11, vecs[i].ra0, vecs[i].ra1);
            #2;
            check($sformatf("vec%0d_p0", i), rd_data[31:0],  vecs[i].exp0);
            check($sformatf("vec%0d_p1", i), rd_data[63:32], vecs[i].exp1);
            check($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
        end
        step();
        idle();

        // load hazard on r5, resolved by same-cycle load return
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd5;
        step();
        idle();
        rd(2'b01, 5'd5, 5'd0);
        #2;
        check("hz5_stall", {31'd0, stall}, 32'd1);
        step();
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEAD_BEEF;
        #2;
        check("hz5_fwd_stall", {31'd0, stall}, 32'd0);
        check("hz5_fwd_data", rd_data[31:0], 32'hDEAD_BEEF);
        step();
        ld_valid = 1'b0;
        #2;
        check("hz5_arr_stall", {31'd0, stall}, 32'd0);
        check("hz5_arr_data", rd_data[31:0], 32'hDEAD_BEEF);
        step();
        idle();

        // hazard seen on port 1, and only with rd_en
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd6;
        step();
        idle();
        rd(2'b10, 5'd0, 5'd6);
        #2;
        check("hz6_p1_stall", {31'd0, stall}, 32'd1);
        rd(2'b00, 5'd6, 5'd6);
        #2;
        check("hz6_noen_stall", {31'd0, stall}, 32'd0);
        step();
        ld_valid = 1'b1; ld_addr = 5'd6; ld_data = 32'h66;
        step();
        idle();

        // non-load issue never marks pending
        iss_valid = 1'b1; iss_is_load = 1'b0; iss_dst = 5'd10;
        step();
        idle();
        rd(2'b01, 5'd10, 5'd0);
        #2;
        check("nonload_stall", {31'd0, stall}, 32'd0);
        step();
        idle();

        // zero register ignores writes and load issues
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd31;
        we = 1'b1; wa = 5'd31; wd = 32'hFFFF_FFFF;
        step();
        idle();
        rd(2'b11, 5'd31, 5'd31);
        #2;
        check("zr_stall", {31'd0, stall}, 32'd0);
        check("zr_data", rd_data[31:0], 32'h0);
        step();
        idle();

        // new load wins over same-cycle return
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd9;
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h5;
        step();
        idle();
        rd(2'b01, 5'd9, 5'd0);
        #2;
        check("setclr9_stall", {31'd0, stall}, 32'd1);
        step();
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h9;
        step();
        idle();
        rd(2'b01, 5'd9, 5'd0);
        #2;
        check("clr9_stall", {31'd0, stall}, 32'd0);
        check("clr9_data", rd_data[31:0], 32'h9);
        step();
        idle();

        // reset clears pending bits (and, in the init build, the array)
        we = 1'b1; wa = 5'd20; wd = 32'h1234;
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 5'd12;
        step();
        idle();
        rd(2'b01, 5'd12, 5'd0);
        #2;
        check("pend12_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        step();
        #2;
`ifdef REGFILE_SB_INIT_EN
        check("rst2_stall", {31'd0, stall}, 32'd1);
`else
        check("rst2_stall", {31'd0, stall}, 32'd0);
`endif
        rst = 1'b0;
        idle();
`ifdef REGFILE_SB_INIT_EN
        // restart the clear from mid-sequence
        repeat (10) step();
        #2;
        check("mid_init_cnt", {27'd0, dbg_cnt}, 32'd10);
        rst = 1'b1;
        step();
        #2;
        check("restart_cnt", {27'd0, dbg_cnt}, 32'd0);
        rst = 1'b0;
        count_busy(busy_n);
        check("restart_busy_len", busy_n, 32'd31);
        step();
`else
        step();
`endif
        rd(2'b11, 5'd12, 5'd20);
        #2;
        check("post_rst_stall", {31'd0, stall}, 32'd0);
`ifdef REGFILE_SB_INIT_EN
        check("post_rst_r20", rd_data[63:32], 32'h0);
`else
        check("post_rst_r20", rd_data[63:32], 32'h1234);
`endif
        step();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
